// File: rtl/dla_regif_mov_q_if.sv
// Register-bus, command-channel and status signals between software, the move queue and the
// data mover. The slave modport is the queue's view; master is the host/mover view.
interface dla_regif_mov_q_if #(
  parameter int unsigned GB_AW  = 13,
  parameter int unsigned LB_AW  = 11,
  parameter int unsigned LB_SKW = 6,
  parameter int unsigned LEN_W  = 13,
  parameter int unsigned ITER_W = 6
) ();
  logic              ctrl_wen;
  logic              src0_wen;
  logic              src1_wen;
  logic              dest_wen;
  logic [31:0]       regif_wdata;
  logic [31:0]       ctrl_rdata;
  logic [31:0]       src0_rdata;
  logic [31:0]       src1_rdata;
  logic [31:0]       dest_rdata;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [GB_AW-1:0]  cmd_gb_addr;
  logic [GB_AW-1:0]  cmd_gb_skip;
  logic [LB_AW-1:0]  cmd_lb_addr;
  logic [LB_SKW-1:0] cmd_lb_skip;
  logic [LEN_W-1:0]  cmd_len;
  logic [ITER_W-1:0] cmd_iter;
  logic              mov_done;
  logic              busy;
  logic              irq;

  modport master (
    output ctrl_wen, src0_wen, src1_wen, dest_wen, regif_wdata, cmd_ready, mov_done,
    input  ctrl_rdata, src0_rdata, src1_rdata, dest_rdata, cmd_valid, cmd_gb_addr,
           cmd_gb_skip, cmd_lb_addr, cmd_lb_skip, cmd_len, cmd_iter, busy, irq
  );

  modport slave (
    input  ctrl_wen, src0_wen, src1_wen, dest_wen, regif_wdata, cmd_ready, mov_done,
    output ctrl_rdata, src0_rdata, src1_rdata, dest_rdata, cmd_valid, cmd_gb_addr,
           cmd_gb_skip, cmd_lb_addr, cmd_lb_skip, cmd_len, cmd_iter, busy, irq
  );
endinterface

// File: rtl/dla_regif_mov_q.sv
// GB-to-LB move register interface: shadow registers snapshot into a QDEPTH-entry command
// queue on CTRL go, with outstanding/done tracking, sticky error and maskable interrupt.
module dla_regif_mov_q #(
  parameter int unsigned GB_AW  = 13,
  parameter int unsigned LB_AW  = 11,
  parameter int unsigned LB_SKW = 6,
  parameter int unsigned LEN_W  = 13,
  parameter int unsigned ITER_W = 6,
  parameter int unsigned QDEPTH = 4
) (
  input logic              clk,
  input logic              rst,
  dla_regif_mov_q_if.slave io_bus
);

  localparam int unsigned PW = $clog2(QDEPTH);
  localparam int unsigned CW = PW + 1;

  typedef struct packed {
    logic [GB_AW-1:0]  gb_addr;
    logic [GB_AW-1:0]  gb_skip;
    logic [LB_AW-1:0]  lb_addr;
    logic [LB_SKW-1:0] lb_skip;
    logic [LEN_W-1:0]  len;
    logic [ITER_W-1:0] iter;
  } desc_t;

  desc_t         r_shadow;
  desc_t         r_mem [QDEPTH];
  desc_t         r_head;
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [3:0]    r_outst;
  logic [7:0]    r_done_cnt;
  logic          r_err;
  logic          r_irq_en;
  logic          r_irq_pend;

  logic          w_go;
  logic          w_clr;
  logic          w_full;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic [CW-1:0] w_count_d;
  logic [PW-1:0] w_rd_ptr_d;
  desc_t         w_head_d;
  logic [3:0]    w_outst_d;
  logic          w_outst_err;
  logic          w_err_set;
  logic          w_irq_set;
  logic [3:0]    w_pend4;

  assign w_go   = io_bus.ctrl_wen & io_bus.regif_wdata[31];
  assign w_clr  = io_bus.ctrl_wen & io_bus.regif_wdata[30];
  assign w_full = (r_count == CW'(QDEPTH));
  assign w_pop  = (r_count != '0) & io_bus.cmd_ready;
  // A full queue still takes a go when the head leaves in the same cycle.
  assign w_push = w_go & (~w_full | w_pop);
  assign w_drop = w_go & w_full & ~w_pop;

  assign w_rd_ptr_d = w_pop ? r_rd_ptr + PW'(1) : r_rd_ptr;

  always_comb begin
    w_count_d = r_count;
    if (w_push && !w_pop) begin
      w_count_d = r_count + CW'(1);
    end else if (w_pop && !w_push) begin
      w_count_d = r_count - CW'(1);
    end
  end

  // The new head is the entry being pushed when everything ahead of it is gone.
  always_comb begin
    w_head_d = r_mem[w_rd_ptr_d];
    if (w_push && (w_rd_ptr_d == r_wr_ptr)) begin
      w_head_d = r_shadow;
    end
  end

  always_comb begin
    w_outst_d   = r_outst;
    w_outst_err = 1'b0;
    if (w_pop && !io_bus.mov_done) begin
      if (r_outst == 4'hf) begin
        w_outst_err = 1'b1;
      end else begin
        w_outst_d = r_outst + 4'd1;
      end
    end else if (!w_pop && io_bus.mov_done) begin
      if (r_outst == 4'h0) begin
        w_outst_err = 1'b1;
      end else begin
        w_outst_d = r_outst - 4'd1;
      end
    end
  end

  assign w_err_set = w_drop | w_outst_err;
  assign w_irq_set = io_bus.mov_done & (w_outst_d == 4'h0) & (w_count_d == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shadow <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_head     <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_outst    <= '0;
      r_done_cnt <= '0;
      r_err      <= 1'b0;
      r_irq_en   <= 1'b0;
      r_irq_pend <= 1'b0;
    end else begin
      if (io_bus.src0_wen) begin
        r_shadow.len     <= io_bus.regif_wdata[16 +: LEN_W];
        r_shadow.gb_addr <= io_bus.regif_wdata[0 +: GB_AW];
      end
      if (io_bus.src1_wen) begin
        r_shadow.iter    <= io_bus.regif_wdata[16 +: ITER_W];
        r_shadow.gb_skip <= io_bus.regif_wdata[0 +: GB_AW];
      end
      if (io_bus.dest_wen) begin
        r_shadow.lb_skip <= io_bus.regif_wdata[16 +: LB_SKW];
        r_shadow.lb_addr <= io_bus.regif_wdata[0 +: LB_AW];
      end
      if (w_push) begin
        r_mem[r_wr_ptr] <= r_shadow;
        r_wr_ptr        <= r_wr_ptr + PW'(1);
      end
      r_rd_ptr <= w_rd_ptr_d;
      r_count  <= w_count_d;
      // Head holds its last value while the queue is empty.
      if (w_count_d != '0) begin
        r_head <= w_head_d;
      end
      r_outst <= w_outst_d;
      if (w_clr) begin
        r_done_cnt <= {7'd0, io_bus.mov_done};
      end else if (io_bus.mov_done && (r_done_cnt != 8'hff)) begin
        r_done_cnt <= r_done_cnt + 8'd1;
      end
      if (w_clr) begin
        r_err <= 1'b0;
      end else if (w_err_set) begin
        r_err <= 1'b1;
      end
      if (w_clr) begin
        r_irq_pend <= 1'b0;
      end else if (w_irq_set) begin
        r_irq_pend <= 1'b1;
      end
      if (io_bus.ctrl_wen) begin
        r_irq_en <= io_bus.regif_wdata[29];
      end
    end
  end

  assign w_pend4 = 4'(r_count);

  assign io_bus.cmd_valid   = (r_count != '0);
  assign io_bus.cmd_gb_addr = r_head.gb_addr;
  assign io_bus.cmd_gb_skip = r_head.gb_skip;
  assign io_bus.cmd_lb_addr = r_head.lb_addr;
  assign io_bus.cmd_lb_skip = r_head.lb_skip;
  assign io_bus.cmd_len     = r_head.len;
  assign io_bus.cmd_iter    = r_head.iter;
  assign io_bus.busy        = (r_count != '0) | (r_outst != 4'h0);
  assign io_bus.irq         = r_irq_pend & r_irq_en;

  assign io_bus.ctrl_rdata = {io_bus.busy, r_err, r_irq_en, r_irq_pend, 4'd0, r_done_cnt,
                              4'd0, r_outst, 4'd0, w_pend4};

  always_comb begin
    io_bus.src0_rdata = '0;
    io_bus.src0_rdata[16 +: LEN_W] = r_shadow.len;
    io_bus.src0_rdata[0 +: GB_AW]  = r_shadow.gb_addr;
    io_bus.src1_rdata = '0;
    io_bus.src1_rdata[16 +: ITER_W] = r_shadow.iter;
    io_bus.src1_rdata[0 +: GB_AW]   = r_shadow.gb_skip;
    io_bus.dest_rdata = '0;
    io_bus.dest_rdata[16 +: LB_SKW] = r_shadow.lb_skip;
    io_bus.dest_rdata[0 +: LB_AW]   = r_shadow.lb_addr;
  end

endmodule

// File: tb/tb_dla_regif_mov_q.sv
// Directed plus random checks of dla_regif_mov_q against a queue-based reference model.
module tb_dla_regif_mov_q;
  localparam int GB_AW  = 13;
  localparam int LB_AW  = 11;
  localparam int LB_SKW = 6;
  localparam int LEN_W  = 13;
  localparam int ITER_W = 6;
  localparam int QDEPTH = 4;

  typedef struct {
    int gb_addr; int gb_skip; int lb_addr; int lb_skip; int len; int iter;
  } d_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;

  d_t mq[$];
  d_t m_sh;
  d_t m_head;
  int m_outst, m_dc;
  bit m_err, m_en, m_ip;
  int dut_popped[$];

  dla_regif_mov_q_if #(.GB_AW(GB_AW), .LB_AW(LB_AW), .LB_SKW(LB_SKW), .LEN_W(LEN_W),
                       .ITER_W(ITER_W)) bus ();

  dla_regif_mov_q #(.GB_AW(GB_AW), .LB_AW(LB_AW), .LB_SKW(LB_SKW), .LEN_W(LEN_W),
                    .ITER_W(ITER_W), .QDEPTH(QDEPTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    mq.delete();
    m_sh = '{default: 0};
    m_head = '{default: 0};
    m_outst = 0; m_dc = 0; m_err = 0; m_en = 0; m_ip = 0;
  endfunction

  function automatic int fld(input logic [31:0] w, input int lsb, input int width);
    return int'((w >> lsb) & ((32'd1 << width) - 32'd1));
  endfunction

  // One clock of the spec rules, applied to the inputs currently on the bus.
  function automatic void model_step();
    bit pop, done, go, clr, eset, iset;
    logic [31:0] w;
    d_t gone;
    w = bus.regif_wdata;
    pop = (mq.size() != 0) && bus.cmd_ready;
    done = bus.mov_done;
    go = bus.ctrl_wen && w[31];
    clr = bus.ctrl_wen && w[30];
    eset = go && (mq.size() == QDEPTH) && !pop;
    if (pop) gone = mq.pop_front();
    if (go && !eset) mq.push_back(m_sh);
    if (pop && !done) begin
      if (m_outst == 15) eset = 1; else m_outst++;
    end else if (done && !pop) begin
      if (m_outst == 0) eset = 1; else m_outst--;
    end
    iset = done && (m_outst == 0) && (mq.size() == 0);
    if (clr) m_dc = done ? 1 : 0;
    else if (done && m_dc < 255) m_dc++;
    m_err = clr ? 1'b0 : (m_err | eset);
    m_ip  = clr ? 1'b0 : (m_ip | iset);
    if (bus.ctrl_wen) m_en = w[29];
    if (bus.src0_wen) begin m_sh.len = fld(w, 16, LEN_W); m_sh.gb_addr = fld(w, 0, GB_AW); end
    if (bus.src1_wen) begin m_sh.iter = fld(w, 16, ITER_W); m_sh.gb_skip = fld(w, 0, GB_AW); end
    if (bus.dest_wen) begin
      m_sh.lb_skip = fld(w, 16, LB_SKW); m_sh.lb_addr = fld(w, 0, LB_AW);
    end
    if (mq.size() != 0) m_head = mq[0];
  endfunction

  task automatic check_all(input string tag);
    int pend;
    bit busy;
    logic [31:0] ctrl;
    pend = mq.size();
    busy = (pend != 0) || (m_outst != 0);
    ctrl = {busy, m_err, m_en, m_ip, 4'd0, 8'(m_dc), 4'd0, 4'(m_outst), 4'd0, 4'(pend)};
    chk({tag, ".valid"}, bus.cmd_valid, pend != 0);
    chk({tag, ".gb_addr"}, bus.cmd_gb_addr, m_head.gb_addr);
    chk({tag, ".gb_skip"}, bus.cmd_gb_skip, m_head.gb_skip);
    chk({tag, ".lb_addr"}, bus.cmd_lb_addr, m_head.lb_addr);
    chk({tag, ".lb_skip"}, bus.cmd_lb_skip, m_head.lb_skip);
    chk({tag, ".len"}, bus.cmd_len, m_head.len);
    chk({tag, ".iter"}, bus.cmd_iter, m_head.iter);
    chk({tag, ".ctrl"}, bus.ctrl_rdata, ctrl);
    chk({tag, ".src0"}, bus.src0_rdata, (m_sh.len << 16) | m_sh.gb_addr);
    chk({tag, ".src1"}, bus.src1_rdata, (m_sh.iter << 16) | m_sh.gb_skip);
    chk({tag, ".dest"}, bus.dest_rdata, (m_sh.lb_skip << 16) | m_sh.lb_addr);
    chk({tag, ".busy"}, bus.busy, busy);
    chk({tag, ".irq"}, bus.irq, m_ip && m_en);
  endtask

  task automatic cyc(input string tag);
    if (bus.cmd_valid && bus.cmd_ready) dut_popped.push_back(int'(bus.cmd_gb_addr));
    model_step();
    @(posedge clk);
    #1;
    bus.ctrl_wen = 0; bus.src0_wen = 0; bus.src1_wen = 0; bus.dest_wen = 0;
    bus.mov_done = 0;
    check_all(tag);
  endtask

  // which: 0=CTRL 1=SRC0 2=SRC1 3=DEST
  task automatic wreg(input int which, input logic [31:0] d, input string tag);
    bus.regif_wdata = d;
    bus.ctrl_wen = (which == 0);
    bus.src0_wen = (which == 1);
    bus.src1_wen = (which == 2);
    bus.dest_wen = (which == 3);
    cyc(tag);
  endtask

  initial begin
    logic [31:0] c;
    bus.ctrl_wen = 0; bus.src0_wen = 0; bus.src1_wen = 0; bus.dest_wen = 0;
    bus.regif_wdata = 0; bus.cmd_ready = 0; bus.mov_done = 0;
    model_reset();
    @(posedge clk);
    #1;
    check_all("reset");
    rst = 0;

    // 1: single descriptor reaches the head one cycle after go
    wreg(1, 32'h0040_0123, "t1_src0");
    wreg(2, 32'h0003_0010, "t1_src1");
    wreg(3, 32'h0002_0055, "t1_dest");
    wreg(0, 32'h8000_0000, "t1_go");
    chk("t1_valid", bus.cmd_valid, 1);
    chk("t1_gb_addr", bus.cmd_gb_addr, 'h123);
    chk("t1_len", bus.cmd_len, 'h40);
    chk("t1_gb_skip", bus.cmd_gb_skip, 'h10);
    chk("t1_iter", bus.cmd_iter, 3);
    chk("t1_lb_addr", bus.cmd_lb_addr, 'h55);
    chk("t1_lb_skip", bus.cmd_lb_skip, 2);
    chk("t1_busy", bus.busy, 1);

    // 2: overflow drops the fifth go and sets err; FIFO order on drain
    bus.cmd_ready = 1;
    cyc("t2_pop0");
    bus.cmd_ready = 0;
    dut_popped.delete();
    for (int i = 1; i <= 5; i++) begin
      wreg(1, i, "t2_src0");
      wreg(0, 32'h8000_0000, "t2_go");
    end
    c = bus.ctrl_rdata;
    chk("t2_pend", c[3:0], 4);
    chk("t2_err", c[30], 1);
    bus.cmd_ready = 1;
    repeat (4) cyc("t2_drain");
    bus.cmd_ready = 0;
    chk("t2_npop", dut_popped.size(), 4);
    for (int i = 0; i < 4 && i < dut_popped.size(); i++) chk("t2_order", dut_popped[i], i + 1);
    chk("t2_empty", bus.cmd_valid, 0);

    // 3: go on a full queue with a simultaneous pop is accepted
    wreg(0, 32'h4000_0000, "t3_clr");
    for (int i = 11; i <= 14; i++) begin
      wreg(1, i, "t3_src0");
      wreg(0, 32'h8000_0000, "t3_go");
    end
    wreg(1, 15, "t3_src0");
    bus.cmd_ready = 1;
    wreg(0, 32'h8000_0000, "t3_go_pop");
    c = bus.ctrl_rdata;
    chk("t3_pend", c[3:0], 4);
    chk("t3_err", c[30], 0);
    repeat (4) cyc("t3_drain");
    bus.cmd_ready = 0;
    for (int k = 0; k < 20 && m_outst > 0; k++) begin
      bus.mov_done = 1;
      cyc("t3_done");
    end
    c = bus.ctrl_rdata;
    chk("t3_outst0", c[11:8], 0);
    wreg(0, 32'h4000_0000, "t3_clr2");

    // 4: completions, done counter and interrupt, then clear
    wreg(0, 32'h2000_0000, "t4_en");
    wreg(0, 32'hA000_0000, "t4_go");
    wreg(0, 32'hA000_0000, "t4_go");
    bus.cmd_ready = 1;
    cyc("t4_pop");
    cyc("t4_pop");
    bus.cmd_ready = 0;
    c = bus.ctrl_rdata;
    chk("t4_outst2", c[11:8], 2);
    bus.mov_done = 1;
    cyc("t4_done1");
    c = bus.ctrl_rdata;
    chk("t4_outst1", c[11:8], 1);
    chk("t4_irq_lo", bus.irq, 0);
    bus.mov_done = 1;
    cyc("t4_done2");
    c = bus.ctrl_rdata;
    chk("t4_outst0", c[11:8], 0);
    chk("t4_dcnt2", c[23:16], 2);
    chk("t4_irq_hi", bus.irq, 1);
    wreg(0, 32'h6000_0000, "t4_clr");
    c = bus.ctrl_rdata;
    chk("t4_irq_clr", bus.irq, 0);
    chk("t4_dcnt0", c[23:16], 0);
    chk("t4_irq_en", c[29], 1);

    // 5: spurious completion
    bus.mov_done = 1;
    cyc("t5_spur");
    c = bus.ctrl_rdata;
    chk("t5_err", c[30], 1);
    chk("t5_dcnt", c[23:16], 1);
    chk("t5_outst", c[11:8], 0);

    // 6: asynchronous reset mid-transfer
    wreg(0, 32'h4000_0000, "t6_clr");
    wreg(1, 32'h0100_0777, "t6_src0");
    wreg(0, 32'h8000_0000, "t6_go");
    wreg(0, 32'h8000_0000, "t6_go");
    bus.cmd_ready = 1;
    cyc("t6_pop");
    cyc("t6_pop");
    bus.cmd_ready = 0;
    repeat (3) wreg(0, 32'h8000_0000, "t6_go3");
    c = bus.ctrl_rdata;
    chk("t6_pend3", c[3:0], 3);
    chk("t6_outst2", c[11:8], 2);
    #2;
    rst = 1;
    #1;
    model_reset();
    check_all("t6_rst");
    chk("t6_rst_ctrl", bus.ctrl_rdata, 0);
    chk("t6_rst_valid", bus.cmd_valid, 0);
    chk("t6_rst_busy", bus.busy, 0);
    @(posedge clk);
    #1;
    rst = 0;
    wreg(0, 32'h8000_0000, "t6_go_post");
    chk("t6_post_valid", bus.cmd_valid, 1);
    chk("t6_post_addr", bus.cmd_gb_addr, 0);
    chk("t6_post_len", bus.cmd_len, 0);

    // random traffic against the model
    for (int n = 0; n < 400; n++) begin
      logic [31:0] w;
      w = $urandom;
      bus.src0_wen = ($urandom_range(0, 3) == 0);
      bus.src1_wen = ($urandom_range(0, 3) == 0);
      bus.dest_wen = ($urandom_range(0, 3) == 0);
      bus.ctrl_wen = ($urandom_range(0, 2) == 0);
      w[30] = ($urandom_range(0, 7) == 0);
      bus.regif_wdata = w;
      bus.cmd_ready = $urandom_range(0, 1);
      bus.mov_done = (m_outst > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
      cyc("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
